// File: rtl/signal_frame_serializer_pkg.sv
// Shared definitions for the frame serializer.
//   WORD_SIZE / N_POINTS / IDX_W : word width, samples per frame, index width
//   FRAME_W                      : width of one flat frame bus (re or im)
//   state_t                      : controller state encoding
//   slice_lsb(k)                 : bit offset of sample k inside a flat frame bus
package signal_frame_serializer_pkg;

    localparam int WORD_SIZE = 16;
    localparam int N_POINTS  = 16;
    localparam int IDX_W     = 4;
    localparam int FRAME_W   = N_POINTS * WORD_SIZE;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int slice_lsb(input int k);
        return k * WORD_SIZE;
    endfunction

endpackage

// File: rtl/signal_frame_serializer_if.sv
// Frame-in / sample-out bundle of the serializer.
//   frame_valid, frame_re, frame_im, frame_ready : parallel frame capture side
//   out_valid, out_ready, out_re, out_im,
//   out_idx, out_last                            : streamed sample side
//   overflow, clear_ovf                          : sticky drop flag and its clear
// slave modport is the serializer; master modport is its environment.
interface signal_frame_serializer_if;
    import signal_frame_serializer_pkg::*;

    logic                   frame_valid;
    logic [FRAME_W-1:0]     frame_re;
    logic [FRAME_W-1:0]     frame_im;
    logic                   frame_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_SIZE-1:0]   out_re;
    logic [WORD_SIZE-1:0]   out_im;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   overflow;
    logic                   clear_ovf;

    modport slave (
        input  frame_valid, frame_re, frame_im, out_ready, clear_ovf,
        output frame_ready, out_valid, out_re, out_im, out_idx, out_last, overflow
    );

    modport master (
        output frame_valid, frame_re, frame_im, out_ready, clear_ovf,
        input  frame_ready, out_valid, out_re, out_im, out_idx, out_last, overflow
    );

endinterface

// File: rtl/signal_frame_serializer_frame_capture_bank.sv
// Capture buffer for one complex frame.
//   clk, rst_n         : clock, async active-low reset (buffer clears to zero)
//   load               : capture all samples of frame_re / frame_im
//   frame_re, frame_im : flat frame buses, sample k at [k*WORD_SIZE +: WORD_SIZE]
//   rd_idx             : registered sample index driven by the controller
//   rd_re, rd_im       : selected sample
module signal_frame_serializer_frame_capture_bank
    import signal_frame_serializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [FRAME_W-1:0]   frame_re,
    input  logic [FRAME_W-1:0]   frame_im,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [WORD_SIZE-1:0] rd_re,
    output logic [WORD_SIZE-1:0] rd_im
);

    logic [WORD_SIZE-1:0] re_q [N_POINTS];
    logic [WORD_SIZE-1:0] im_q [N_POINTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_POINTS; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < N_POINTS; k++) begin
                re_q[k] <= frame_re[slice_lsb(k) +: WORD_SIZE];
                im_q[k] <= frame_im[slice_lsb(k) +: WORD_SIZE];
            end
        end
    end

    // rd_idx comes straight from a register, so the read data depends on
    // state only and never on this cycle's inputs.
    assign rd_re = re_q[rd_idx];
    assign rd_im = im_q[rd_idx];

endmodule

// File: rtl/signal_frame_serializer.sv
// Captures a 16-point complex frame on a strobe and streams it out one
// sample per cycle (index 0..15) over a valid/ready handshake.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave side of signal_frame_serializer_if
//
// state  | meaning
// IDLE   | buffer free, frame_ready=1, out_valid=0
// STREAM | presenting buffer[idx]; a new frame is accepted only alongside
//        | the transfer of sample 15
module signal_frame_serializer
    import signal_frame_serializer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    signal_frame_serializer_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ovf_q, ovf_d;
    logic               load;
    logic               streaming;
    logic               at_last;
    logic               xfer;
    logic               frame_ready;
    logic               drop;

    assign streaming   = (state_q == STREAM);
    assign at_last     = (idx_q == LAST_IDX);
    assign xfer        = streaming & bus.out_ready;
    assign frame_ready = (state_q == IDLE) | (streaming & at_last & bus.out_ready);
    assign drop        = bus.frame_valid & ~frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (!at_last) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        idx_d = '0;
                        // A frame arriving with the last transfer is chained
                        // without a bubble.
                        if (bus.frame_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    // A drop in the same cycle as clear_ovf must leave the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    signal_frame_serializer_frame_capture_bank u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .frame_re (bus.frame_re),
        .frame_im (bus.frame_im),
        .rd_idx   (idx_q),
        .rd_re    (bus.out_re),
        .rd_im    (bus.out_im)
    );

    assign bus.frame_ready = frame_ready;
    assign bus.out_valid   = streaming;
    assign bus.out_idx     = idx_q;
    assign bus.out_last    = streaming & at_last;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_signal_frame_serializer.sv
module tb_signal_frame_serializer;
    import signal_frame_serializer_pkg::*;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  idx;
        logic        last;
    } sample_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    signal_frame_serializer_if bus();

    signal_frame_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    sample_t sb[$];
    int total = 0;
    int bad = 0;
    bit bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // re[k] = re_base + k, im[k] = im_base - k; expected samples pushed if accepted
    task automatic load_frame(input logic [15:0] re_base, input logic [15:0] im_base, input bit push);
        sample_t s;
        for (int k = 0; k < N_POINTS; k++) begin
            bus.frame_re[k*WORD_SIZE +: WORD_SIZE] = re_base + 16'(k);
            bus.frame_im[k*WORD_SIZE +: WORD_SIZE] = im_base - 16'(k);
            if (push) begin
                s.re   = re_base + 16'(k);
                s.im   = im_base - 16'(k);
                s.idx  = 4'(k);
                s.last = (k == N_POINTS - 1);
                sb.push_back(s);
            end
        end
        bus.frame_valid = 1'b1;
    endtask

    task automatic strobe(input logic [15:0] re_base, input logic [15:0] im_base, input bit push);
        load_frame(re_base, im_base, push);
        @(posedge clk); #1;
        bus.frame_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        check(name, 64'(sb.size()), 64'(0));
    endtask

    // Monitor: pops and compares on every accepted sample; checks stall stability.
    initial begin
        sample_t cur;
        sample_t exp;
        sample_t held;
        bit held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                cur.re   = bus.out_re;
                cur.im   = bus.out_im;
                cur.idx  = bus.out_idx;
                cur.last = bus.out_last;
                if (held_v) check("stall_hold", 64'(cur), 64'(held));
                if (bus.out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_sample actual=%h required=none", cur);
                    end else begin
                        exp = sb.pop_front();
                        check("sample", 64'(cur), 64'(exp));
                    end
                    held_v = 1'b0;
                end else begin
                    held   = cur;
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.frame_valid = 1'b0;
        bus.frame_re    = '0;
        bus.frame_im    = '0;
        bus.out_ready   = 1'b1;
        bus.clear_ovf   = 1'b0;

        // reset state
        #12;
        check("rst_out_valid",   64'(bus.out_valid),   64'(0));
        check("rst_out_idx",     64'(bus.out_idx),     64'(0));
        check("rst_out_last",    64'(bus.out_last),    64'(0));
        check("rst_overflow",    64'(bus.overflow),    64'(0));
        check("rst_out_re",      64'(bus.out_re),      64'(0));
        check("rst_out_im",      64'(bus.out_im),      64'(0));
        check("rst_frame_ready", 64'(bus.frame_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);

        // single frame: re=k, im=-k
        check("idle_out_valid", 64'(bus.out_valid), 64'(0));
        strobe(16'h0000, 16'h0000, 1'b1);
        check("lat_out_valid", 64'(bus.out_valid), 64'(1));
        check("lat_out_idx",   64'(bus.out_idx),   64'(0));
        drain("single_drain");
        check("single_idle_valid", 64'(bus.out_valid),   64'(0));
        check("single_idle_ready", 64'(bus.frame_ready), 64'(1));

        // backpressure 1,0,0,1,...
        strobe(16'h0200, 16'h1000, 1'b1);
        begin
            int c = 0;
            while (sb.size() != 0 && c < 300) begin
                bus.out_ready = bp_pat[c % 4];
                @(posedge clk); #1;
                c++;
            end
        end
        bus.out_ready = 1'b1;
        check("bp_drain",     64'(sb.size()),      64'(0));
        check("bp_idle_valid", 64'(bus.out_valid), 64'(0));

        // back-to-back: second frame strobed while sample 15 transfers
        strobe(16'h0500, 16'h0000, 1'b1);
        tick(15);
        check("b2b_idx15",       64'(bus.out_idx),     64'(15));
        check("b2b_frame_ready", 64'(bus.frame_ready), 64'(1));
        strobe(16'h0100, 16'h2000, 1'b1);
        check("b2b_out_valid", 64'(bus.out_valid), 64'(1));
        check("b2b_out_idx",   64'(bus.out_idx),   64'(0));
        check("b2b_out_re",    64'(bus.out_re),    64'(16'h0100));
        check("b2b_overflow",  64'(bus.overflow),  64'(0));
        drain("b2b_drain");

        // drop at idx 5
        strobe(16'h0700, 16'h3000, 1'b1);
        tick(5);
        check("drop_frame_ready", 64'(bus.frame_ready), 64'(0));
        strobe(16'hBEE0, 16'h0BAD, 1'b0);
        check("drop_overflow", 64'(bus.overflow), 64'(1));
        check("drop_idx",      64'(bus.out_idx),  64'(6));
        drain("drop_drain");
        tick(2);
        check("drop_no_extra", 64'(bus.out_valid), 64'(0));

        // drop + clear in the same cycle, then clear alone
        strobe(16'h0900, 16'h4000, 1'b1);
        tick(2);
        bus.clear_ovf = 1'b1;
        strobe(16'h7770, 16'h0000, 1'b0);
        bus.clear_ovf = 1'b0;
        check("set_wins_overflow", 64'(bus.overflow), 64'(1));
        bus.clear_ovf = 1'b1;
        tick(1);
        bus.clear_ovf = 1'b0;
        check("clear_overflow", 64'(bus.overflow), 64'(0));
        drain("clear_drain");

        // reset mid-stream at idx 7 (with overflow set by a drop at idx 2)
        strobe(16'h0A00, 16'h5000, 1'b1);
        tick(2);
        strobe(16'h6660, 16'h0000, 1'b0);
        check("mid_overflow_set", 64'(bus.overflow), 64'(1));
        tick(4);
        check("mid_idx7", 64'(bus.out_idx), 64'(7));
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_out_idx",   64'(bus.out_idx),   64'(0));
        check("mid_rst_out_re",    64'(bus.out_re),    64'(0));
        check("mid_rst_overflow",  64'(bus.overflow),  64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        check("mid_rel_frame_ready", 64'(bus.frame_ready), 64'(1));
        check("mid_rel_out_valid",   64'(bus.out_valid),   64'(0));

        // recovery frame after reset
        strobe(16'h0C00, 16'h6000, 1'b1);
        drain("recover_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
